// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
// Cuts the transmitter's free-running AXI-Stream word stream into frames of
// programmable length, separates frames by a programmable idle gap, and stops
// after a programmed frame count or on request. One register slice on output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no run; waiting for cfg_start
// ST_SEND  | accepting upstream words into the slice, building a frame
// ST_GAP   | upstream held off for the programmed number of idle cycles
// ST_DRAIN | run finished upstream; waiting for the slice to empty
module tx_frame_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_num_frames,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_sof,
  output logic                  m_axis_eof,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len, r_word_cnt;
  logic [GAP_WIDTH-1:0]  r_gap, r_gap_cnt;
  logic [CNT_WIDTH-1:0]  r_num, r_issued, r_frames_sent;
  logic                  r_stop_pending, r_done;
  logic                  r_tvalid, r_sof, r_eof;
  logic [DATA_WIDTH-1:0] r_tdata;

  logic w_slice_free, w_up_hs, w_dn_hs, w_last_word, w_stop_req, w_run_end;
  logic w_tready, w_start, w_enter_gap;

  assign w_slice_free = !r_tvalid || m_axis_tready;
  assign w_up_hs      = s_axis_tvalid && w_tready;
  assign w_dn_hs      = r_tvalid && m_axis_tready;
  assign w_start      = (r_state == ST_IDLE) && cfg_start;
  assign w_last_word  = (r_word_cnt == (r_len - LEN_ONE));
  // A stop arriving on the eof cycle itself still ends the run after this frame.
  assign w_stop_req   = r_stop_pending || cfg_stop;
  assign w_run_end    = w_stop_req ||
                        ((r_num != '0) && ((r_issued + CNT_ONE) == r_num));
  assign w_enter_gap  = (r_state == ST_SEND) && (w_state_nxt == ST_GAP);

  assign s_axis_tready = w_tready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_sof    = r_sof;
  assign m_axis_eof    = r_eof;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign frames_sent   = r_frames_sent;

  // State register.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state decode and upstream ready.
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_tready = w_slice_free;
        if (w_up_hs && w_last_word) begin
          if (w_run_end)          w_state_nxt = ST_DRAIN;
          else if (r_gap != '0)   w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_ONE) w_state_nxt = w_stop_req ? ST_DRAIN : ST_SEND;
      end
      ST_DRAIN: begin
        if (w_slice_free) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch run configuration on start; a zero length is treated as one word.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_len <= LEN_ONE;
      r_gap <= '0;
      r_num <= '0;
    end else if (w_start) begin
      r_len <= (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
      r_gap <= cfg_gap;
      r_num <= cfg_num_frames;
    end
  end

  // Stop request is remembered so the current frame can finish first.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset)
      r_stop_pending <= 1'b0;
    else if (w_start)
      r_stop_pending <= cfg_stop;
    else if (cfg_stop && ((r_state == ST_SEND) || (r_state == ST_GAP)))
      r_stop_pending <= 1'b1;
  end

  // Word position within the frame and issued-frame count (wraps).
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_word_cnt <= '0;
      r_issued   <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
      r_issued   <= '0;
    end else if (w_up_hs) begin
      if (w_last_word) begin
        r_word_cnt <= '0;
        r_issued   <= r_issued + CNT_ONE;
      end else begin
        r_word_cnt <= r_word_cnt + LEN_ONE;
      end
    end
  end

  // Inter-frame gap down-counter; terminal count 1 releases the next frame.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset)            r_gap_cnt <= '0;
    else if (w_enter_gap)        r_gap_cnt <= r_gap;
    else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt - GAP_ONE;
  end

  // Output register slice with regenerated frame markers.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
    end else if (w_up_hs) begin
      r_tvalid <= 1'b1;
      r_tdata  <= s_axis_tdata;
      r_sof    <= (r_word_cnt == '0);
      r_eof    <= w_last_word;
    end else if (w_dn_hs) begin
      r_tvalid <= 1'b0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
    end
  end

  // Completed-frame count on the output side, saturating.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset)
      r_frames_sent <= '0;
    else if (w_start)
      r_frames_sent <= '0;
    else if (w_dn_hs && r_eof && (r_frames_sent != {CNT_WIDTH{1'b1}}))
      r_frames_sent <= r_frames_sent + CNT_ONE;
  end

  // End-of-run pulse, coincident with the drop of busy.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_done <= 1'b0;
    else              r_done <= (r_state == ST_DRAIN) && w_slice_free;
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Testbench for tx_frame_scheduler: table of run scenarios driven through a
// common run task with an upstream-to-downstream scoreboard, plus a
// hand-written reset-mid-frame sequence.
module tb_tx_frame_scheduler;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int GW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic          cfg_start, cfg_stop;
  logic [LW-1:0] cfg_frame_len;
  logic [GW-1:0] cfg_gap;
  logic [CW-1:0] cfg_num_frames;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_sof, m_axis_eof;
  logic          busy, done;
  logic [CW-1:0] frames_sent;

  always #5 clk = ~clk;

  tx_frame_scheduler #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_areset   (areset),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_gap        (cfg_gap),
    .cfg_num_frames (cfg_num_frames),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_sof     (m_axis_sof),
    .m_axis_eof     (m_axis_eof),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent)
  );

  typedef struct {
    int len;
    int gap;
    int num;
    bit rnd;          // randomise upstream valid and downstream ready
    int stop_at;      // pulse cfg_stop once this many words are accepted (-1 none)
    bit start_stop;   // cfg_stop together with cfg_start
    int restart_at;   // pulse cfg_start mid-run at this word count (-1 none)
    int exp_words;
    int exp_frames;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } word_t;

  word_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_sof"}, m_axis_sof, 0);
    chk({tag, "_eof"}, m_axis_eof, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_frames_sent"}, frames_sent, 0);
  endtask

  // Runs one scenario from the current point (just after a rising edge).
  task automatic run_vec(input int id, input vec_t v);
    int    len_eff;
    int    cyc, k, up_words, out_words, out_frames, up_eof_cyc, out_eof_cyc;
    bit    seen_done, exp_done, stalled, stop_sent, restart_sent, src_adv, up, dn;
    word_t held, exp_w;
    len_eff = (v.len == 0) ? 1 : v.len;
    cyc = 0; k = 0; up_words = 0; out_words = 0; out_frames = 0;
    up_eof_cyc = -1; out_eof_cyc = -1;
    seen_done = 0; exp_done = 0; stalled = 0; stop_sent = 0; restart_sent = 0;
    held = '{'0, 1'b0, 1'b0};
    sb_q.delete();

    cfg_frame_len  = LW'(v.len);
    cfg_gap        = GW'(v.gap);
    cfg_num_frames = CW'(v.num);
    cfg_start      = 1'b1;
    cfg_stop       = v.start_stop;
    s_axis_tvalid  = 1'b1;
    m_axis_tready  = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_busy_before_start", id), busy, 0);
    chk($sformatf("v%0d_tready_idle", id), s_axis_tready, 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    // Config changes during a run must be ignored.
    cfg_frame_len  = LW'($urandom_range(1, 9));
    cfg_gap        = GW'($urandom_range(0, 5));
    cfg_num_frames = CW'($urandom_range(1, 4));

    while (!seen_done && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      up = s_axis_tvalid && s_axis_tready;
      dn = m_axis_tvalid && m_axis_tready;
      if (cyc == 1) chk($sformatf("v%0d_busy_after_start", id), busy, 1);
      if (exp_done || done) begin
        chk($sformatf("v%0d_done_timing", id), done, exp_done);
        if (exp_done) chk($sformatf("v%0d_busy_fall", id), busy, 0);
      end
      seen_done = done;
      exp_done  = 0;
      chk($sformatf("v%0d_frames_sent", id), frames_sent, out_frames);
      if (stalled) begin
        chk($sformatf("v%0d_stall_valid", id), m_axis_tvalid, 1);
        chk($sformatf("v%0d_stall_data", id), m_axis_tdata, held.data);
        chk($sformatf("v%0d_stall_sof", id), m_axis_sof, held.sof);
        chk($sformatf("v%0d_stall_eof", id), m_axis_eof, held.eof);
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = '{m_axis_tdata, m_axis_sof, m_axis_eof};
      if (dn) begin
        chk($sformatf("v%0d_output_expected", id), sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_w = sb_q.pop_front();
          chk($sformatf("v%0d_w%0d_data", id, out_words), m_axis_tdata, exp_w.data);
          chk($sformatf("v%0d_w%0d_sof", id, out_words), m_axis_sof, exp_w.sof);
          chk($sformatf("v%0d_w%0d_eof", id, out_words), m_axis_eof, exp_w.eof);
        end
        if (!v.rnd && m_axis_sof && out_eof_cyc >= 0)
          chk($sformatf("v%0d_out_gap", id), cyc - out_eof_cyc, v.gap + 1);
        out_words++;
        if (m_axis_eof) begin
          out_frames++;
          out_eof_cyc = cyc;
          exp_done = (out_frames == v.exp_frames);
        end
      end
      src_adv = up;
      if (up) begin
        if (k == 0 && up_eof_cyc >= 0)
          chk($sformatf("v%0d_up_gap_min", id), cyc >= up_eof_cyc + 1 + v.gap, 1);
        sb_q.push_back('{s_axis_tdata, (k == 0), (k == len_eff - 1)});
        if (k == len_eff - 1) begin
          k = 0;
          up_eof_cyc = cyc;
        end else begin
          k++;
        end
        up_words++;
      end

      @(posedge clk); #1;
      if (src_adv) s_axis_tdata = $urandom;
      s_axis_tvalid = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_stop  = 1'b0;
      cfg_start = 1'b0;
      if (v.stop_at >= 0 && !stop_sent && up_words == v.stop_at) begin
        cfg_stop  = 1'b1;
        stop_sent = 1;
      end
      if (v.restart_at >= 0 && !restart_sent && up_words == v.restart_at) begin
        cfg_start    = 1'b1;
        restart_sent = 1;
      end
    end

    cfg_stop  = 1'b0;
    cfg_start = 1'b0;
    chk($sformatf("v%0d_done_seen", id), seen_done, 1);
    chk($sformatf("v%0d_words_total", id), out_words, v.exp_words);
    chk($sformatf("v%0d_frames_total", id), out_frames, v.exp_frames);
    chk($sformatf("v%0d_frames_sent_final", id), frames_sent, v.exp_frames);
    chk($sformatf("v%0d_scoreboard_empty", id), sb_q.size(), 0);
    if (!seen_done) begin
      areset = 1'b1;
      @(posedge clk); #1;
      areset = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_done_single", id), done, 0);
    chk($sformatf("v%0d_busy_idle", id), busy, 0);
    chk($sformatf("v%0d_tready_after", id), s_axis_tready, 0);
    chk($sformatf("v%0d_tvalid_after", id), m_axis_tvalid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[6];
    int   t;
    areset         = 1'b1;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    cfg_frame_len  = '0;
    cfg_gap        = '0;
    cfg_num_frames = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = $urandom;
    m_axis_tready  = 1'b0;

    //          len gap num rnd stop st+sp restart words frames
    vecs[0] = '{4,  2,  3,  0,  -1,  0,    -1,     12,   3};  // basic run
    vecs[1] = '{5,  0,  2,  1,  -1,  0,    -1,     10,   2};  // backpressure
    vecs[2] = '{0,  0,  3,  0,  -1,  0,    -1,     3,    3};  // len=0, gap=0
    vecs[3] = '{8,  3,  0,  0,  10,  0,    -1,     16,   2};  // stop mid frame 2
    vecs[4] = '{6,  1,  0,  0,  -1,  1,    2,      6,    1};  // start+stop, restart
    vecs[5] = '{3,  1,  2,  1,  -1,  0,    -1,     6,    2};  // random flow, gap 1

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk); #1;
    areset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while the slice holds a stalled word.
    cfg_frame_len  = LW'(4);
    cfg_gap        = GW'(0);
    cfg_num_frames = CW'(1);
    cfg_start      = 1'b1;
    s_axis_tvalid  = 1'b1;
    s_axis_tdata   = 32'hA5A5_0001;
    m_axis_tready  = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_axis_tvalid && t < 20);
    chk("rst_seq_slice_full", m_axis_tvalid, 1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk); #1;
    areset        = 1'b0;
    s_axis_tvalid = 1'b0;

    begin
      vec_t vr;
      vr = '{2, 0, 1, 0, -1, 0, -1, 2, 1};
      run_vec(6, vr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Frame-level scheduler for the PRBS transmitter's AXI-Stream output. It sits between the transmitter's `m_axis_*` port and the downstream consumer. It cuts the transmitter's free-running word stream into frames of programmable length, inserts a programmable idle gap between frames and stops after a programmed frame count or on request. It regenerates start-of-frame and end-of-frame markers and reports progress.

## Interface

Parameters:
- `DATA_WIDTH`, 32, stream data width
- `LEN_WIDTH`, 16, width of frame-length and word counters
- `GAP_WIDTH`, 16, width of gap counter
- `CNT_WIDTH`, 16, width of frame counters

Ports:
- `s_axi_aclk`  in  1  single clock
- `s_axi_areset`  in  1  reset, synchronous, active-high
- `cfg_start`  in  1  one-cycle pulse; starts a run (IDLE only)
- `cfg_stop`  in  1  one-cycle pulse; finish the current frame, then stop
- `cfg_frame_len`  in  LEN_WIDTH  words per frame; 0 treated as 1
- `cfg_gap`  in  GAP_WIDTH  idle cycles between frames
- `cfg_num_frames`  in  CNT_WIDTH  frames per run; 0 = continuous until stop
- `s_axis_tvalid`  in  1  transmitter word valid
- `s_axis_tready`  out  1  accept from transmitter
- `s_axis_tdata`  in  DATA_WIDTH  transmitter word
- `m_axis_tvalid`  out  1  output word valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tdata`  out  DATA_WIDTH  output word
- `m_axis_sof`  out  1  first word of frame, qualified by tvalid
- `m_axis_eof`  out  1  last word of frame, qualified by tvalid
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `frames_sent`  out  CNT_WIDTH  frames completed on output this run

## Operation

- Config is latched on accepted `cfg_start`. Changes to the `cfg_*` inputs during a run are ignored.
- The output stage is a single register slice, so it may hold one word. It is free when `!m_axis_tvalid || m_axis_tready`.
- FSM states are IDLE, SEND, GAP and DRAIN.
- **IDLE:** `cfg_start` clears `frames_sent`, the word counter and stop_pending, sets `busy` and moves to SEND. `cfg_stop` is ignored in IDLE unless it arrives with `cfg_start`. In that case start wins, stop_pending is set and exactly one frame is sent.
- **SEND:** `s_axis_tready` = slice free. Each upstream handshake loads the slice and increments the word counter.
  - sof = (word counter == 0).
  - eof = (word counter == len−1).
  - On accepting the eof word, the word counter clears and the issued-frame count increments.
  - Next state is DRAIN if stop_pending, or if `cfg_num_frames` ≠ 0 and issued == `cfg_num_frames`.
  - Otherwise next state is GAP, with the gap counter loaded to `cfg_gap`. If `cfg_gap` == 0, the FSM stays in SEND.
- **GAP:** `s_axis_tready` = 0. The gap counter decrements each cycle; at 1 the FSM returns to SEND.
- **DRAIN:** `s_axis_tready` = 0. The FSM waits for the slice to empty, then pulses `done`, clears `busy` and goes to IDLE.
- `frames_sent` increments on each output handshake with eof=1. It saturates at its maximum value and does not wrap. Issued frames use a separate internal counter, which wraps in continuous mode.
- `cfg_stop` in SEND or GAP sets stop_pending.
  - In SEND, the current frame is completed to its full length.
  - In GAP, the FSM goes to DRAIN at gap end; no new frame starts.
- `cfg_start` while `busy` is ignored.
- `s_axis_tready` is never asserted outside SEND. Words from the transmitter are backpressured, not dropped.

## Timing

- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_sof`=0, `m_axis_eof`=0, `busy`=0, `done`=0, `frames_sent`=0; FSM in IDLE.
- Reset mid-run aborts immediately and discards any word held in the slice.
- `busy` rises the cycle after `cfg_start`. `s_axis_tready` can assert that same cycle.
- Latency: upstream handshake at cycle t gives `m_axis_tvalid` at t+1.
- Throughput: 1 word/cycle inside a frame when `m_axis_tready` is held high.
- Gap: if the eof word is accepted upstream at cycle t, the next sof word is accepted no earlier than t+1+`cfg_gap`.
- `done` is asserted the cycle after the final eof output handshake. `busy` falls in that same cycle.
- `m_axis_tvalid`, data, sof and eof are held stable while `m_axis_tvalid && !m_axis_tready`.

## Test plan

- **Basic run:** len=4, gap=2, num=3, tready=1, transmitter always valid. Expect 12 words; sof on words 0/4/8 and eof on words 3/7/11. Exactly 2 idle cycles between frames. `frames_sent`=3; `done` one cycle after the last eof; `busy`=0 afterwards.
- **Backpressure:** len=5, gap=0, num=2, with `m_axis_tready` toggled pseudo-randomly. Expect 10 words, unchanged while stalled, no loss or duplication, data order equal to input order, back-to-back frames.
- **len=0 / gap=0:** len=0, num=3. Expect 3 single-word frames, each with sof=eof=1, on consecutive cycles.
- **Stop mid-frame:** num=0, len=8, `cfg_stop` pulsed on the 3rd word of frame 2. Expect frame 2 completes with 8 words, then `done`; `frames_sent`=2.
- **Start+stop same cycle, plus start while busy:** expect exactly 1 frame. A second `cfg_start` issued during that frame has no effect.
- **Reset mid-frame:** assert `s_axis_areset` with `m_axis_tvalid`=1 and tready=0. Next cycle expect all outputs at reset values. A new `cfg_start` then produces a frame starting with sof.
